mem_access: RTL and testbench

- Data-memory stage directly downstream of the execute stage. It consumes the ALU result as the effective address, and rs2 as the store data.
- It runs loads and stores over a ready/valid data-memory bus, handling byte-lane steering, write strobes and load sign/zero extension.
- It asserts a stall to freeze PC and register writeback while an access is outstanding.
- It reports misaligned, illegal-op and bus-timeout faults.

---
 rtl/mem_access.sv | 192 +++++++++++++++++++
 tb/tb_mem_access.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - data-memory stage: load/store sequencing over a ready/valid bus
module mem_access #(
  parameter int TIMEOUT = 16,
  parameter int CW      = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic [1:0]      lane_q;
  logic            fault_q;
  logic [1:0]      cause_q;

  logic            start, illegal, misaligned, timed_out;
  logic [3:0]      wstrb_nxt;
  logic [31:0]     wdata_nxt;
  logic [31:0]     load_ext;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign start       = mem_rd | mem_wr;
  assign timed_out   = (cnt >= CW'(TIMEOUT - 1));
  assign fault       = fault_q;
  assign fault_cause = cause_q;

  // mem_wr wins when both strobes are high, so legality follows the store table then
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (mem_wr) begin
      illegal = mem_op[2] | (mem_op[1:0] == 2'b11);
    end else begin
      illegal = (mem_op[1:0] == 2'b11) | (mem_op[2:1] == 2'b11);
    end
    misaligned = ((mem_op[1:0] == 2'b01) & addr[0]) |
                 ((mem_op[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  always_comb begin
    wstrb_nxt = 4'b0000;
    wdata_nxt = 32'h0;
    if (mem_wr) begin
      case (mem_op[1:0])
        2'b00: begin
          wstrb_nxt = 4'b0001 << addr[1:0];
          wdata_nxt = {4{wdata_in[7:0]}};
        end
        2'b01: begin
          wstrb_nxt = 4'b0011 << addr[1:0];
          wdata_nxt = {2{wdata_in[15:0]}};
        end
        default: begin
          wstrb_nxt = 4'b1111;
          wdata_nxt = wdata_in;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = dmem_rdata[8*lane_q +: 8];
    half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q[1:0])
      2'b00:   load_ext = op_q[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = op_q[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    dmem_req  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          stall     = 1'b1;
          state_nxt = (illegal | misaligned) ? DONE : REQ;
        end
      end
      REQ: begin
        stall    = 1'b1;
        dmem_req = 1'b1;
        if (dmem_ready)     state_nxt = dmem_we ? DONE : WAIT;
        else if (timed_out) state_nxt = DONE;
      end
      WAIT: begin
        stall = 1'b1;
        if (dmem_rvalid || timed_out) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      op_q       <= 3'b000;
      lane_q     <= 2'b00;
      fault_q    <= 1'b0;
      cause_q    <= 2'b00;
      load_data  <= 32'h0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0;
      dmem_wstrb <= 4'b0000;
      dmem_wdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              fault_q   <= 1'b1;
              cause_q   <= 2'b10;
              load_data <= 32'h0;
            end else if (misaligned) begin
              fault_q   <= 1'b1;
              cause_q   <= 2'b01;
              load_data <= 32'h0;
            end else begin
              cnt        <= '0;
              op_q       <= mem_op;
              lane_q     <= addr[1:0];
              dmem_we    <= mem_wr;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_wstrb <= wstrb_nxt;
              dmem_wdata <= wdata_nxt;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (dmem_ready) begin
            if (dmem_we) load_data <= 32'h0;
          end else if (timed_out) begin
            fault_q   <= 1'b1;
            cause_q   <= 2'b11;
            load_data <= 32'h0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (dmem_rvalid) begin
            load_data <= load_ext;
          end else if (timed_out) begin
            fault_q   <= 1'b1;
            cause_q   <= 2'b11;
            load_data <= 32'h0;
          end
        end
        DONE: begin
          fault_q <= 1'b0;
          cause_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - scoreboard bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata_in;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_cause;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;

  mem_access #(.TIMEOUT(16), .CW(5)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_op(mem_op),
    .addr(addr), .wdata_in(wdata_in), .stall(stall), .load_data(load_data),
    .done(done), .fault(fault), .fault_cause(fault_cause), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ld;
    logic        f;
    logic [1:0]  c;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every retirement is matched against the oldest expected response
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no retirement");
      end else begin
        mon_e = sbq.pop_front();
        chk("load_data", load_data, mon_e.ld);
        chk("fault", {31'h0, fault}, {31'h0, mon_e.f});
        chk("fault_cause", {30'h0, fault_cause}, {30'h0, mon_e.c});
      end
    end
  end

  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int rdy_dly, input int rv_dly,
                        input logic [31:0] exp_ld, input logic exp_f, input logic [1:0] exp_c,
                        input int exp_lat, input int exp_req,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wd);
    exp_t e;
    int   cyc, stall_n, req_n, wait_n;
    bit   seen_done, bus_bad, in_wait, acc_now;
    e.ld = exp_ld; e.f = exp_f; e.c = exp_c;
    sbq.push_back(e);
    cyc = 0; stall_n = 0; req_n = 0; wait_n = 0;
    seen_done = 0; bus_bad = 0; in_wait = 0;
    dmem_rdata = rdat;
    @(posedge clk); #1;
    mem_rd = rd; mem_wr = wr; mem_op = op; addr = a; wdata_in = wd;
    while (!seen_done && cyc < 60) begin
      @(negedge clk);
      acc_now = 0;
      if (done) begin
        seen_done = 1;
        chk({name, ".latency"}, cyc, exp_lat);
        chk({name, ".stall_in_done"}, {31'h0, stall}, 32'h0);
        dmem_ready = 0;
        dmem_rvalid = 0;
      end else begin
        if (stall) stall_n++;
        if (dmem_req) begin
          if (dmem_addr !== {a[31:2], 2'b00} || dmem_we !== wr ||
              dmem_wstrb !== exp_strb || (wr && dmem_wdata !== exp_wd))
            bus_bad = 1;
          dmem_ready = (req_n == rdy_dly);
          acc_now = dmem_ready;
          req_n++;
        end else begin
          dmem_ready = 0;
        end
        if (in_wait) begin
          dmem_rvalid = (wait_n == rv_dly);
          wait_n++;
        end else begin
          dmem_rvalid = 0;
        end
      end
      @(posedge clk); #1;
      mem_rd = 0; mem_wr = 0;
      if (acc_now && !wr) in_wait = 1;
      cyc++;
    end
    dmem_ready = 0;
    dmem_rvalid = 0;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL %s.no_done: got no done in 60 cycles expected done", name);
    end
    chk({name, ".stall_cycles"}, stall_n, exp_lat);
    chk({name, ".req_cycles"}, req_n, exp_req);
    if (exp_req > 0) chk({name, ".bus_outputs"}, {31'h0, bus_bad}, 32'h0);
  endtask

  initial begin
    int dc;
    rst = 1; mem_rd = 0; mem_wr = 0; mem_op = 0; addr = 0; wdata_in = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.stall", {31'h0, stall}, 32'h0);
    chk("rst.done", {31'h0, done}, 32'h0);
    chk("rst.fault", {29'h0, fault, fault_cause}, 32'h0);
    chk("rst.load_data", load_data, 32'h0);
    chk("rst.bus", {27'h0, dmem_req, dmem_wstrb}, 32'h0);
    chk("rst.dmem_addr", dmem_addr, 32'h0);
    chk("rst.dmem_wdata", dmem_wdata, 32'h0);
    @(posedge clk); #1 rst = 0;

    access("lb",   1, 0, 3'b000, 32'h00001003, 0, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 2'b00, 3, 1, 4'b0000, 0);
    access("lbu",  1, 0, 3'b100, 32'h00001003, 0, 32'h80FF1234, 0, 0, 32'h00000080, 0, 2'b00, 3, 1, 4'b0000, 0);
    access("sh",   0, 1, 3'b001, 32'h00002002, 32'h1234ABCD, 0, 0, 0, 32'h0, 0, 2'b00, 2, 1, 4'b1100, 32'hABCDABCD);
    access("sb",   0, 1, 3'b000, 32'h00002001, 32'h0000005A, 0, 0, 0, 32'h0, 0, 2'b00, 2, 1, 4'b0010, 32'h5A5A5A5A);
    access("lh",   1, 0, 3'b001, 32'h00001002, 0, 32'h80017FFF, 0, 0, 32'hFFFF8001, 0, 2'b00, 3, 1, 4'b0000, 0);
    access("lhu",  1, 0, 3'b101, 32'h00001000, 0, 32'h8001F00F, 0, 0, 32'h0000F00F, 0, 2'b00, 3, 1, 4'b0000, 0);
    access("lw_mis", 1, 0, 3'b010, 32'h00001002, 0, 0, 0, 0, 32'h0, 1, 2'b01, 1, 0, 4'b0000, 0);
    access("ld_ill", 1, 0, 3'b011, 32'h00001000, 0, 0, 0, 0, 32'h0, 1, 2'b10, 1, 0, 4'b0000, 0);
    access("st_ill_mis", 0, 1, 3'b101, 32'h00001001, 0, 0, 0, 0, 32'h0, 1, 2'b10, 1, 0, 4'b0000, 0);
    access("rdwr_sw", 1, 1, 3'b010, 32'h00003000, 32'hCAFEF00D, 0, 0, 0, 32'h0, 0, 2'b00, 2, 1, 4'b1111, 32'hCAFEF00D);
    access("lw_slow", 1, 0, 3'b010, 32'h00001000, 0, 32'hDEADBEEF, 3, 1, 32'hDEADBEEF, 0, 2'b00, 7, 4, 4'b0000, 0);

    // reset while a load is in WAIT, followed by a stray rvalid
    dc = done_cnt;
    dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_rd = 1; mem_op = 3'b010; addr = 32'h00003000; dmem_ready = 1;
    @(posedge clk); #1;
    mem_rd = 0;
    @(posedge clk); #1;
    dmem_ready = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0; dmem_rvalid = 1;
    @(posedge clk); #1;
    dmem_rvalid = 0;
    @(negedge clk);
    chk("rstwait.stall", {31'h0, stall}, 32'h0);
    chk("rstwait.dmem_req", {31'h0, dmem_req}, 32'h0);
    chk("rstwait.load_data", load_data, 32'h0);
    repeat (3) @(negedge clk);
    chk("rstwait.no_done", done_cnt - dc, 0);

    access("lw_tmo",  1, 0, 3'b010, 32'h00004000, 0, 0, 99, 0, 32'h0, 1, 2'b11, 17, 16, 4'b0000, 0);
    access("sw_last", 0, 1, 3'b010, 32'h00004004, 32'h11223344, 0, 15, 0, 32'h0, 0, 2'b00, 17, 16, 4'b1111, 32'h11223344);
    access("lw_rvtmo", 1, 0, 3'b010, 32'h00004008, 0, 0, 0, 99, 32'h0, 1, 2'b11, 17, 1, 4'b0000, 0);
    access("lbu_after", 1, 0, 3'b100, 32'h00005002, 0, 32'h00A50000, 0, 0, 32'h000000A5, 0, 2'b00, 3, 1, 4'b0000, 0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
